v_pipe_query_mp: RTL and testbench

Multi-channel, parametrised successor to the single-port list query pipeline. Up to CH_N independent query channels share one state-table read port through a round-robin arbiter. Each channel gets a tagged, fixed one-cycle-latency response carrying key, volume, list size and error. The update-pipeline hazard check is generalised to UPD_STAGES_N stages, with a selectable busy policy (error-out or hold-off), plus a saturating error counter for observability.

---
 rtl/v_pipe_query_mp_pkg.sv | 30 +++
 rtl/v_pipe_query_mp_cells.sv | 41 ++++
 rtl/v_pipe_query_mp_rr_arb.sv | 57 +++++
 rtl/v_pipe_query_mp.sv | 141 ++++++++++++++
 tb/tb_v_pipe_query_mp.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/v_pipe_query_mp_pkg.sv
// Shared types for the list query pipeline: product IDs, levels and the packed
// per-product state record read from the state RAM.
package v_pkg;

    localparam int ENTRIES_N    = 256;
    localparam int ID_W         = $clog2(ENTRIES_N);
    localparam int LEVELS_N     = 4;
    localparam int LEVEL_W      = $clog2(LEVELS_N);
    localparam int KEY_W        = 8;
    localparam int VOL_W        = 16;
    localparam int LS_W         = $clog2(LEVELS_N + 1);
    localparam int LUT_CH_N     = 2;
    localparam int UPD_STAGES_N = 4;

    typedef logic [ID_W-1:0]    id_t;
    typedef logic [ID_W-1:0]    addr_t;
    typedef logic [LEVEL_W-1:0] level_t;
    typedef logic [KEY_W-1:0]   key_t;
    typedef logic [VOL_W-1:0]   volume_t;
    typedef logic [LS_W-1:0]    listsize_t;

    // One entry per product; vld[l] says whether level l holds live data.
    typedef struct packed {
        logic [LEVELS_N-1:0]            vld;
        logic [LEVELS_N-1:0][KEY_W-1:0] key;
        logic [LEVELS_N-1:0][VOL_W-1:0] volume;
        listsize_t                      listsize;
    } state_t;

endpackage

// File: rtl/v_pipe_query_mp_cells.sv
// Small library cells: binary-to-one-hot level decoder and a one-hot select mux.
module v_dec #(
    parameter int N = 4,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [W-1:0] sel,
    output logic [N-1:0] onehot
);

    // Decode the binary select into a one-hot vector.
    always_comb begin
        onehot = '0;
        for (int i = 0; i < N; i++) begin
            onehot[i] = (int'(sel) == i);
        end
    end

endmodule

module v_mux #(
    parameter int N = 4,
    parameter int W = 8
) (
    input  logic [N-1:0][W-1:0] din,
    input  logic [N-1:0]        sel,
    output logic [W-1:0]        dout
);

    // AND-OR select; an all-zero select yields zero.
    always_comb begin
        dout = '0;
        for (int i = 0; i < N; i++) begin
            if (sel[i]) begin
                dout = dout | din[i];
            end else begin
                dout = dout;
            end
        end
    end

endmodule

// File: rtl/v_pipe_query_mp_rr_arb.sv
// Round-robin arbiter: one-hot grant, search starts at the pointer, pointer
// advances past the winner and holds when nothing is granted.
module rr_arb #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt
);

    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    logic [PTR_W-1:0] ptr_r;
    logic [PTR_W-1:0] gidx_s;
    logic             found_s;

    // First requester at or after the pointer, wrapping around.
    always_comb begin
        int idx_v;
        gnt     = '0;
        gidx_s  = '0;
        found_s = 1'b0;
        idx_v   = 0;
        for (int i = 0; i < N; i++) begin
            idx_v = int'(ptr_r) + i;
            if (idx_v >= N) begin
                idx_v = idx_v - N;
            end else begin
                idx_v = idx_v;
            end
            if (!found_s && req[idx_v]) begin
                gnt[idx_v] = 1'b1;
                gidx_s     = PTR_W'(idx_v);
                found_s    = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Pointer update.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r <= '0;
        end else if (found_s) begin
            if (int'(gidx_s) == N - 1) begin
                ptr_r <= '0;
            end else begin
                ptr_r <= gidx_s + PTR_W'(1);
            end
        end else begin
            ptr_r <= ptr_r;
        end
    end

endmodule

// File: rtl/v_pipe_query_mp.sv
// Multi-channel list query pipe: channels share the state RAM read port via a
// round-robin arbiter; responses come one cycle after accept, tagged by channel.
module v_pipe_query_mp
    import v_pkg::*;
#(
    parameter int CH_N         = v_pkg::LUT_CH_N,
    parameter int UPD_STAGES_N = v_pkg::UPD_STAGES_N,
    parameter int BUSY_MODE    = 0,
    parameter int CNT_W        = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [CH_N-1:0]                  i_lut_vld,
    input  id_t [CH_N-1:0]                   i_lut_prod_id,
    input  level_t [CH_N-1:0]                i_lut_level,
    output logic [CH_N-1:0]                  o_lut_rdy,
    output logic                             o_rsp_vld,
    output logic [CH_N-1:0]                  o_rsp_ch,
    output key_t                             o_rsp_key,
    output volume_t                          o_rsp_size,
    output logic                             o_rsp_error,
    output listsize_t                        o_rsp_listsize,
    input  state_t                           i_state_rdata,
    output logic                             o_state_ren,
    output addr_t                            o_state_raddr,
    input  logic [UPD_STAGES_N-1:0]          i_upd_vld_r,
    input  id_t [UPD_STAGES_N-1:0]           i_upd_prod_id_r,
    output logic [CNT_W-1:0]                 o_err_cnt
);

    localparam logic HOLD_OFF = (BUSY_MODE != 0);

    logic [CH_N-1:0]     busy_s;
    logic [CH_N-1:0]     elig_s;
    logic [CH_N-1:0]     gnt_s;
    id_t                 sel_id_s;
    level_t              sel_level_s;
    logic                sel_busy_s;
    logic [LEVELS_N-1:0] dec_s;
    logic                rsp_err_s;

    logic                vld_r;
    logic [CH_N-1:0]     ch_r;
    logic [LEVELS_N-1:0] dec_r;
    logic                busy_err_r;
    logic [CNT_W-1:0]    cnt_r;

    // Hazard: channel's ID matches any valid in-flight update stage.
    always_comb begin
        busy_s = '0;
        for (int c = 0; c < CH_N; c++) begin
            for (int s = 0; s < UPD_STAGES_N; s++) begin
                busy_s[c] = busy_s[c] |
                            (i_upd_vld_r[s] & (i_upd_prod_id_r[s] == i_lut_prod_id[c]));
            end
        end
    end

    assign elig_s = i_lut_vld & ~(busy_s & {CH_N{HOLD_OFF}}) & {CH_N{~rst}};

    rr_arb #(.N(CH_N)) u_arb (
        .clk (clk),
        .rst (rst),
        .req (elig_s),
        .gnt (gnt_s)
    );

    // Payload of the granted channel; the grant is one-hot so an OR-mux suffices.
    always_comb begin
        sel_id_s    = '0;
        sel_level_s = '0;
        sel_busy_s  = 1'b0;
        for (int c = 0; c < CH_N; c++) begin
            if (gnt_s[c]) begin
                sel_id_s    = sel_id_s | i_lut_prod_id[c];
                sel_level_s = sel_level_s | i_lut_level[c];
                sel_busy_s  = sel_busy_s | busy_s[c];
            end else begin
                sel_id_s    = sel_id_s;
                sel_level_s = sel_level_s;
                sel_busy_s  = sel_busy_s;
            end
        end
    end

    assign o_lut_rdy     = gnt_s;
    assign o_state_ren   = |gnt_s;
    assign o_state_raddr = sel_id_s;

    v_dec #(.N(LEVELS_N), .W(LEVEL_W)) u_dec (
        .sel    (sel_level_s),
        .onehot (dec_s)
    );

    // S1 capture of the accepted query.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_r      <= 1'b0;
            ch_r       <= '0;
            dec_r      <= '0;
            busy_err_r <= 1'b0;
        end else begin
            vld_r      <= |gnt_s;
            ch_r       <= gnt_s;
            dec_r      <= dec_s;
            busy_err_r <= sel_busy_s & ~HOLD_OFF;
        end
    end

    v_mux #(.N(LEVELS_N), .W(KEY_W)) u_key_mux (
        .din  (i_state_rdata.key),
        .sel  (dec_r),
        .dout (o_rsp_key)
    );

    v_mux #(.N(LEVELS_N), .W(VOL_W)) u_vol_mux (
        .din  (i_state_rdata.volume),
        .sel  (dec_r),
        .dout (o_rsp_size)
    );

    assign rsp_err_s      = busy_err_r | ((dec_r & i_state_rdata.vld) == '0);
    assign o_rsp_vld      = vld_r;
    assign o_rsp_ch       = ch_r;
    assign o_rsp_error    = rsp_err_s;
    assign o_rsp_listsize = i_state_rdata.listsize;

    // Saturating count of error responses.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (vld_r && rsp_err_s && (cnt_r != {CNT_W{1'b1}})) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign o_err_cnt = cnt_r;

endmodule

// File: tb/tb_v_pipe_query_mp.sv
// Directed bench: dut0 is BUSY_MODE=0 with a 4-bit counter, dut1 is BUSY_MODE=1;
// both share stimulus, each has its own state RAM model over a common table.
module tb_v_pipe_query_mp;
    import v_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [1:0]   lut_vld;
    id_t [1:0]    lut_id;
    level_t [1:0] lut_level;
    logic [3:0]   upd_vld;
    id_t [3:0]    upd_id;

    logic [1:0] rdy0, rdy1, ch0, ch1;
    logic       rvld0, rvld1, err0, err1, ren0, ren1;
    key_t       key0, key1;
    volume_t    size0, size1;
    listsize_t  ls0, ls1;
    addr_t      raddr0, raddr1;
    logic [3:0]  cnt0;
    logic [15:0] cnt1;
    state_t     rdata0, rdata1;
    state_t     mem [ENTRIES_N];

    int n_cmp = 0;
    int n_bad = 0;

    v_pipe_query_mp #(.CH_N(2), .UPD_STAGES_N(4), .BUSY_MODE(0), .CNT_W(4)) dut0 (
        .clk(clk), .rst(rst), .i_lut_vld(lut_vld), .i_lut_prod_id(lut_id),
        .i_lut_level(lut_level), .o_lut_rdy(rdy0), .o_rsp_vld(rvld0), .o_rsp_ch(ch0),
        .o_rsp_key(key0), .o_rsp_size(size0), .o_rsp_error(err0), .o_rsp_listsize(ls0),
        .i_state_rdata(rdata0), .o_state_ren(ren0), .o_state_raddr(raddr0),
        .i_upd_vld_r(upd_vld), .i_upd_prod_id_r(upd_id), .o_err_cnt(cnt0));

    v_pipe_query_mp #(.CH_N(2), .UPD_STAGES_N(4), .BUSY_MODE(1), .CNT_W(16)) dut1 (
        .clk(clk), .rst(rst), .i_lut_vld(lut_vld), .i_lut_prod_id(lut_id),
        .i_lut_level(lut_level), .o_lut_rdy(rdy1), .o_rsp_vld(rvld1), .o_rsp_ch(ch1),
        .o_rsp_key(key1), .o_rsp_size(size1), .o_rsp_error(err1), .o_rsp_listsize(ls1),
        .i_state_rdata(rdata1), .o_state_ren(ren1), .o_state_raddr(raddr1),
        .i_upd_vld_r(upd_vld), .i_upd_prod_id_r(upd_id), .o_err_cnt(cnt1));

    // State RAM models: data valid the cycle after the read enable.
    always @(posedge clk) begin
        if (ren0) rdata0 <= mem[raddr0];
        if (ren1) rdata1 <= mem[raddr1];
    end

    typedef struct {
        logic [1:0] vld;
        id_t        id0;
        level_t     lv0;
        id_t        id1;
        level_t     lv1;
        logic [3:0] uvld;
        id_t        uid;
        logic [1:0] rdy;
        logic       rvld;
        logic [1:0] ch;
        key_t       key;
        volume_t    size;
        listsize_t  ls;
        logic       err;
        logic [3:0] cnt;
    } vec_t;

    vec_t tbl [22];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] v, input id_t i0, input level_t l0,
                         input id_t i1, input level_t l1, input logic [3:0] uv, input id_t uid);
        lut_vld      = v;
        lut_id[0]    = i0;
        lut_level[0] = l0;
        lut_id[1]    = i1;
        lut_level[1] = l1;
        upd_vld      = uv;
        for (int s = 0; s < 4; s++) upd_id[s] = uid;
    endtask

    initial begin
        for (int e = 0; e < ENTRIES_N; e++) mem[e] = '0;
        mem[5].vld = 4'b0100; mem[5].key[2] = 8'hAB; mem[5].volume[2] = 16'h1234;
        mem[5].listsize = 3'd3;
        for (int l = 0; l < 4; l++) begin
            mem[3].key[l] = 8'h30 + 8'(l); mem[3].volume[l] = 16'h0300 + 16'(l);
            mem[7].key[l] = 8'h70 + 8'(l); mem[7].volume[l] = 16'h0700 + 16'(l);
            mem[9].key[l] = 8'h90 + 8'(l); mem[9].volume[l] = 16'h0900 + 16'(l);
        end
        mem[3].vld = 4'b1111; mem[3].listsize = 3'd4;
        mem[7].vld = 4'b0011; mem[7].listsize = 3'd2;
        mem[9].vld = 4'b0000; mem[9].listsize = 3'd0;

        //         vld    id0  lv0   id1  lv1   uvld     uid   rdy   rvld  ch     key     size       ls    err   cnt
        tbl[0]  = '{2'b00, 8'd0, 2'd0, 8'd0, 2'd0, 4'b0000, 8'd0, 2'b00, 1'b0, 2'b00, 8'h00, 16'h0000, 3'd0, 1'b0, 4'd0};
        tbl[1]  = '{2'b01, 8'd5, 2'd2, 8'd0, 2'd0, 4'b0000, 8'd0, 2'b01, 1'b0, 2'b00, 8'h00, 16'h0000, 3'd0, 1'b0, 4'd0};
        tbl[2]  = '{2'b00, 8'd0, 2'd0, 8'd0, 2'd0, 4'b0000, 8'd0, 2'b00, 1'b1, 2'b01, 8'hAB, 16'h1234, 3'd3, 1'b0, 4'd0};
        tbl[3]  = '{2'b11, 8'd3, 2'd0, 8'd3, 2'd1, 4'b0000, 8'd0, 2'b10, 1'b0, 2'b00, 8'h00, 16'h0000, 3'd0, 1'b0, 4'd0};
        tbl[4]  = '{2'b11, 8'd3, 2'd0, 8'd3, 2'd1, 4'b0000, 8'd0, 2'b01, 1'b1, 2'b10, 8'h31, 16'h0301, 3'd4, 1'b0, 4'd0};
        tbl[5]  = '{2'b11, 8'd3, 2'd0, 8'd3, 2'd1, 4'b0000, 8'd0, 2'b10, 1'b1, 2'b01, 8'h30, 16'h0300, 3'd4, 1'b0, 4'd0};
        tbl[6]  = '{2'b11, 8'd3, 2'd0, 8'd3, 2'd1, 4'b0000, 8'd0, 2'b01, 1'b1, 2'b10, 8'h31, 16'h0301, 3'd4, 1'b0, 4'd0};
        tbl[7]  = '{2'b11, 8'd3, 2'd0, 8'd3, 2'd1, 4'b0000, 8'd0, 2'b10, 1'b1, 2'b01, 8'h30, 16'h0300, 3'd4, 1'b0, 4'd0};
        tbl[8]  = '{2'b11, 8'd3, 2'd0, 8'd3, 2'd1, 4'b0000, 8'd0, 2'b01, 1'b1, 2'b10, 8'h31, 16'h0301, 3'd4, 1'b0, 4'd0};
        tbl[9]  = '{2'b00, 8'd0, 2'd0, 8'd0, 2'd0, 4'b0000, 8'd0, 2'b00, 1'b1, 2'b01, 8'h30, 16'h0300, 3'd4, 1'b0, 4'd0};
        tbl[10] = '{2'b10, 8'd0, 2'd0, 8'd7, 2'd0, 4'b1000, 8'd7, 2'b10, 1'b0, 2'b00, 8'h00, 16'h0000, 3'd0, 1'b0, 4'd0};
        tbl[11] = '{2'b00, 8'd0, 2'd0, 8'd0, 2'd0, 4'b0000, 8'd0, 2'b00, 1'b1, 2'b10, 8'h70, 16'h0700, 3'd2, 1'b1, 4'd0};
        tbl[12] = '{2'b00, 8'd0, 2'd0, 8'd0, 2'd0, 4'b0000, 8'd0, 2'b00, 1'b0, 2'b00, 8'h00, 16'h0000, 3'd0, 1'b0, 4'd1};
        tbl[13] = '{2'b01, 8'd7, 2'd3, 8'd0, 2'd0, 4'b0001, 8'd7, 2'b01, 1'b0, 2'b00, 8'h00, 16'h0000, 3'd0, 1'b0, 4'd1};
        tbl[14] = '{2'b00, 8'd0, 2'd0, 8'd0, 2'd0, 4'b0000, 8'd0, 2'b00, 1'b1, 2'b01, 8'h73, 16'h0703, 3'd2, 1'b1, 4'd1};
        tbl[15] = '{2'b00, 8'd0, 2'd0, 8'd0, 2'd0, 4'b0000, 8'd0, 2'b00, 1'b0, 2'b00, 8'h00, 16'h0000, 3'd0, 1'b0, 4'd2};
        tbl[16] = '{2'b10, 8'd0, 2'd0, 8'd9, 2'd1, 4'b0000, 8'd0, 2'b10, 1'b0, 2'b00, 8'h00, 16'h0000, 3'd0, 1'b0, 4'd2};
        tbl[17] = '{2'b00, 8'd0, 2'd0, 8'd0, 2'd0, 4'b0000, 8'd0, 2'b00, 1'b1, 2'b10, 8'h91, 16'h0901, 3'd0, 1'b1, 4'd2};
        tbl[18] = '{2'b00, 8'd0, 2'd0, 8'd0, 2'd0, 4'b0000, 8'd0, 2'b00, 1'b0, 2'b00, 8'h00, 16'h0000, 3'd0, 1'b0, 4'd3};
        tbl[19] = '{2'b01, 8'd5, 2'd2, 8'd0, 2'd0, 4'b0010, 8'd8, 2'b01, 1'b0, 2'b00, 8'h00, 16'h0000, 3'd0, 1'b0, 4'd3};
        tbl[20] = '{2'b00, 8'd0, 2'd0, 8'd0, 2'd0, 4'b0000, 8'd0, 2'b00, 1'b1, 2'b01, 8'hAB, 16'h1234, 3'd3, 1'b0, 4'd3};
        tbl[21] = '{2'b00, 8'd0, 2'd0, 8'd0, 2'd0, 4'b0000, 8'd0, 2'b00, 1'b0, 2'b00, 8'h00, 16'h0000, 3'd0, 1'b0, 4'd3};

        // Reset: requests present but nothing may be granted.
        rst = 1'b1;
        drive(2'b11, 8'd5, 2'd2, 8'd5, 2'd2, 4'b0000, 8'd0);
        @(negedge clk);
        chk("rst_rdy0", 32'(rdy0), 32'h0);
        chk("rst_rdy1", 32'(rdy1), 32'h0);
        chk("rst_ren0", 32'(ren0), 32'h0);
        chk("rst_rsp_vld0", 32'(rvld0), 32'h0);
        chk("rst_rsp_ch0", 32'(ch0), 32'h0);
        chk("rst_cnt0", 32'(cnt0), 32'h0);
        chk("rst_rsp_vld1", 32'(rvld1), 32'h0);
        chk("rst_cnt1", 32'(cnt1), 32'h0);
        drive(2'b00, 8'd0, 2'd0, 8'd0, 2'd0, 4'b0000, 8'd0);
        step();
        rst = 1'b0;

        for (int i = 0; i < 22; i++) begin
            drive(tbl[i].vld, tbl[i].id0, tbl[i].lv0, tbl[i].id1, tbl[i].lv1,
                  tbl[i].uvld, tbl[i].uid);
            @(negedge clk);
            chk($sformatf("v%0d_rdy", i), 32'(rdy0), 32'(tbl[i].rdy));
            chk($sformatf("v%0d_rsp_vld", i), 32'(rvld0), 32'(tbl[i].rvld));
            chk($sformatf("v%0d_cnt", i), 32'(cnt0), 32'(tbl[i].cnt));
            if (tbl[i].rvld) begin
                chk($sformatf("v%0d_ch", i), 32'(ch0), 32'(tbl[i].ch));
                chk($sformatf("v%0d_key", i), 32'(key0), 32'(tbl[i].key));
                chk($sformatf("v%0d_size", i), 32'(size0), 32'(tbl[i].size));
                chk($sformatf("v%0d_ls", i), 32'(ls0), 32'(tbl[i].ls));
                chk($sformatf("v%0d_err", i), 32'(err0), 32'(tbl[i].err));
            end
            step();
        end

        // Saturation: counter is 3; twelve invalid queries reach 15, one more holds.
        drive(2'b01, 8'd9, 2'd0, 8'd0, 2'd0, 4'b0000, 8'd0);
        for (int k = 0; k < 12; k++) step();
        drive(2'b00, 8'd0, 2'd0, 8'd0, 2'd0, 4'b0000, 8'd0);
        step();
        step();
        @(negedge clk);
        chk("sat_reach_max", 32'(cnt0), 32'd15);
        drive(2'b01, 8'd9, 2'd0, 8'd0, 2'd0, 4'b0000, 8'd0);
        step();
        drive(2'b00, 8'd0, 2'd0, 8'd0, 2'd0, 4'b0000, 8'd0);
        @(negedge clk);
        chk("sat_rsp_err", 32'(err0), 32'h1);
        step();
        step();
        @(negedge clk);
        chk("sat_hold_max", 32'(cnt0), 32'd15);

        // Hold-off mode: ch1 busy for 3 cycles, ch0 keeps winning meanwhile.
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        drive(2'b11, 8'd3, 2'd2, 8'd7, 2'd1, 4'b1000, 8'd7);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("m1_busy_rdy%0d", k), 32'(rdy1), 32'h1);
            if (k > 0) begin
                chk($sformatf("m1_ch0_tag%0d", k), 32'(ch1), 32'h1);
                chk($sformatf("m1_ch0_key%0d", k), 32'(key1), 32'h32);
                chk($sformatf("m1_ch0_err%0d", k), 32'(err1), 32'h0);
            end
            step();
        end
        upd_vld = 4'b0000;
        @(negedge clk);
        chk("m1_clear_rdy", 32'(rdy1), 32'h2);
        step();
        drive(2'b00, 8'd0, 2'd0, 8'd0, 2'd0, 4'b0000, 8'd0);
        @(negedge clk);
        chk("m1_ch1_vld", 32'(rvld1), 32'h1);
        chk("m1_ch1_tag", 32'(ch1), 32'h2);
        chk("m1_ch1_key", 32'(key1), 32'h71);
        chk("m1_ch1_err", 32'(err1), 32'h0);
        step();

        // Reset the cycle after an accept: response dropped, counter cleared, ch0 next.
        drive(2'b11, 8'd9, 2'd0, 8'd9, 2'd0, 4'b0000, 8'd0);
        step();
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_rdy", 32'(rdy0), 32'h0);
        chk("mid_rst_ren", 32'(ren0), 32'h0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_rsp_vld", 32'(rvld0), 32'h0);
        chk("post_rst_cnt", 32'(cnt0), 32'h0);
        chk("post_rst_grant", 32'(rdy0), 32'h1);
        step();
        drive(2'b00, 8'd0, 2'd0, 8'd0, 2'd0, 4'b0000, 8'd0);
        @(negedge clk);
        chk("post_rst_rsp_tag", 32'(ch0), 32'h1);
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
